// File: rtl/param_ring_buffer.sv
// Single-clock ring buffer with registered read data and registered status flags.
// A write into a full buffer is either dropped or replaces the oldest entry, depending on OVERWRITE.
module param_ring_buffer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter bit OVERWRITE = 1'b0,
    parameter int AF_LEVEL  = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic              drop_oldest;
    logic [AW:0]       count_next;

    // Occupancy update clamped to 0..DEPTH; inc and dec together cancel.
    function automatic logic [AW:0] sat_count(input logic [AW:0] cnt, input logic inc, input logic dec);
        logic [AW:0] res;
        res = cnt;
        if (inc && !dec && cnt != FULL_CNT)
            res = cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            res = cnt - 1'b1;
        return res;
    endfunction

    always_comb begin
        rd_acc      = rd_en && !empty;
        wr_acc      = wr_en && (!full || OVERWRITE || rd_acc);
        // Overwrite on a full buffer: the oldest word is pushed out, occupancy unchanged.
        drop_oldest = wr_acc && full && !rd_acc;
        count_next  = sat_count(count, wr_acc && !drop_oldest, rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            rd_valid    <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            data_out    <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc || drop_oldest)
                rd_ptr <= rd_ptr + 1'b1;
            if (rd_acc)
                data_out <= mem[rd_ptr];
            count       <= count_next;
            empty       <= (count_next == '0);
            full        <= (count_next == FULL_CNT);
            almost_full <= (count_next >= AF_CNT);
            rd_valid    <= rd_acc;
            overflow    <= wr_en && full && !rd_acc;
            underflow   <= rd_en && empty;
        end
    end

    // Storage carries no reset; contents become unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wr_ptr] <= data_in;
    end

endmodule
